// File: rtl/vpu_ub_writeback_if.sv
// rtl/vpu_ub_writeback_if.sv - unified buffer row write bus between collector and UB
interface vpu_ub_writeback_if #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [N*DATA_W-1:0] wr_data_out;
    logic [ADDR_W-1:0]   wr_addr_out;
    logic                wr_valid_out;
    logic                wr_ready_in;

    // Collector side drives the row, UB side answers with ready
    modport master (
        output wr_data_out,
        output wr_addr_out,
        output wr_valid_out,
        input  wr_ready_in
    );

    modport slave (
        input  wr_data_out,
        input  wr_addr_out,
        input  wr_valid_out,
        output wr_ready_in
    );
endinterface

// File: rtl/vpu_ub_writeback.sv
// rtl/vpu_ub_writeback.sv - N-lane skew-absorbing writeback collector for the unified buffer
module vpu_ub_writeback #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 2,
    parameter int DATA_W               = 16,
    parameter int FIFO_DEPTH           = 4,
    parameter int ADDR_W               = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_start,
    input  logic [ADDR_W-1:0]                      cfg_base_addr,
    input  logic [15:0]                            cfg_row_count,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_W-1:0] lane_data_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]        lane_valid_in,
    vpu_ub_writeback_if.master                     ub,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow_err
);
    localparam int N     = SYSTOLIC_ARRAY_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]  FULL_LEVEL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SYSTOLIC_ARRAY_WIDTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FINISH  = 2'd2;

    logic [1:0]        state;
    logic [15:0]       row_count_q;
    logic [15:0]       rows_popped;
    logic [15:0]       rows_accepted;
    logic [ADDR_W-1:0] next_addr;

    logic [DATA_W-1:0] fifo_mem [N][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [N];
    logic [PTR_W-1:0]  wr_ptr   [N];
    logic [PTR_W:0]    fill     [N];

    logic              in_collect;
    logic              all_lanes_ready;
    logic              out_free;
    logic              row_pop;
    logic              row_accept;
    logic [N-1:0]      lane_push;
    logic [N-1:0]      lane_push_ok;
    logic [N-1:0]      lane_drop;
    logic [N*DATA_W-1:0] row_heads;

    assign in_collect = (state == ST_COLLECT);
    assign busy       = in_collect;
    assign done       = (state == ST_FINISH);
    assign out_free   = !ub.wr_valid_out || ub.wr_ready_in;
    assign row_accept = ub.wr_valid_out && ub.wr_ready_in;

    // A row leaves the FIFOs only when every lane has a word, the output slot frees up and rows remain
    assign row_pop = in_collect && all_lanes_ready && out_free && (rows_popped < row_count_q);

    // Per-lane occupancy, push acceptance and overflow detection
    always_comb begin
        all_lanes_ready = 1'b1;
        lane_push       = '0;
        lane_push_ok    = '0;
        lane_drop       = '0;
        for (int i = 0; i < N; i++) begin
            if (fill[i] == '0) begin
                all_lanes_ready = 1'b0;
            end
            lane_push[i]    = in_collect && lane_valid_in[i];
            // A full FIFO still takes a word when the same cycle pops its head
            lane_push_ok[i] = lane_push[i] && ((fill[i] != FULL_LEVEL) || row_pop);
            lane_drop[i]    = lane_push[i] && (fill[i] == FULL_LEVEL) && !row_pop;
        end
    end

    // Gather the head word of every lane into one aligned row
    always_comb begin
        row_heads = '0;
        for (int i = 0; i < N; i++) begin
            row_heads[i*DATA_W +: DATA_W] = fifo_mem[i][rd_ptr[i]];
        end
    end

    // Lane FIFO storage; contents need no reset because fill levels gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (lane_push_ok[i]) begin
                fifo_mem[i][wr_ptr[i]] <= lane_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Lane FIFO pointers; leftovers are flushed whenever no transfer is collecting
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || !in_collect) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                fill[i]   <= '0;
            end else begin
                if (lane_push_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (row_pop) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                fill[i] <= fill[i] + (PTR_W+1)'(lane_push_ok[i]) - (PTR_W+1)'(row_pop);
            end
        end
    end

    // Transfer sequencing, row/address counters and the output row register
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            row_count_q     <= '0;
            rows_popped     <= '0;
            rows_accepted   <= '0;
            next_addr       <= '0;
            overflow_err    <= 1'b0;
            ub.wr_valid_out <= 1'b0;
            ub.wr_data_out  <= '0;
            ub.wr_addr_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        row_count_q   <= cfg_row_count;
                        next_addr     <= cfg_base_addr;
                        rows_popped   <= '0;
                        rows_accepted <= '0;
                        overflow_err  <= 1'b0;
                        state         <= (cfg_row_count == 16'd0) ? ST_FINISH : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (|lane_drop) begin
                        overflow_err <= 1'b1;
                    end
                    if (row_pop) begin
                        ub.wr_valid_out <= 1'b1;
                        ub.wr_data_out  <= row_heads;
                        ub.wr_addr_out  <= next_addr;
                        next_addr       <= next_addr + ROW_STRIDE;
                        rows_popped     <= rows_popped + 16'd1;
                    end else if (ub.wr_ready_in) begin
                        ub.wr_valid_out <= 1'b0;
                    end
                    if (row_accept) begin
                        rows_accepted <= rows_accepted + 16'd1;
                        if (rows_accepted == row_count_q - 16'd1) begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
